// File: rtl/clock_ctl_pkg.sv
// Shared definitions for the front-panel clock controller.
package clock_ctl_pkg;

    localparam int STATE_W = 2;

    // Controller state encoding; also exported on the state output.
    localparam logic [STATE_W-1:0] ST_STOPPED = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUNNING = 2'd1;
    localparam logic [STATE_W-1:0] ST_STEP    = 2'd2;
    localparam logic [STATE_W-1:0] ST_HALTED  = 2'd3;

endpackage

// File: rtl/step_debounce.sv
// Step push-button conditioning: two-flop synchronizer, level debouncer
// and rising-edge detector producing a one-cycle step request.
module step_debounce
    import clock_ctl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic _reset,
    input  logic step_btn,
    output logic step_req
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value on the last differing sample before the level is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             deb_level_r;
    logic             deb_prev_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize the raw button, accept a new level after a stable run, remember last level.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            sync1_r     <= 1'b0;
            sync2_r     <= 1'b0;
            deb_level_r <= 1'b0;
            deb_prev_r  <= 1'b0;
            cnt_r       <= '0;
        end else begin
            sync1_r    <= step_btn;
            sync2_r    <= sync1_r;
            deb_prev_r <= deb_level_r;
            if (sync2_r != deb_level_r) begin
                if (cnt_r == CNT_LAST) begin
                    deb_level_r <= sync2_r;
                    cnt_r       <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    // Only the press (rising debounced edge) requests a step; release does nothing.
    assign step_req = deb_level_r & ~deb_prev_r;

endmodule

// File: rtl/clock_ctl.sv
// Front-panel clock controller: turns run switch, step button and CPU halt
// into a registered one-cycle clock-enable pulse plus a two-phase bit.
module clock_ctl
    import clock_ctl_pkg::*;
#(
    parameter int DIV_W           = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               _reset,
    input  logic               run_sw,
    input  logic               step_btn,
    input  logic               halt,
    input  logic [DIV_W-1:0]   div,
    output logic               tick,
    output logic               phase,
    output logic               running,
    output logic [STATE_W-1:0] state
);

    logic               step_req_s;
    logic [STATE_W-1:0] state_r;
    logic [STATE_W-1:0] state_nxt_s;
    logic [DIV_W-1:0]   div_cnt_r;
    logic [DIV_W-1:0]   div_cnt_nxt_s;
    logic               tick_r;
    logic               tick_nxt_s;
    logic               phase_r;
    logic               running_r;

    step_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clk     (clk),
        ._reset  (_reset),
        .step_btn(step_btn),
        .step_req(step_req_s)
    );

    // Next-state, divider and tick decision; run_sw off always has top priority when leaving RUNNING/HALTED.
    always_comb begin
        state_nxt_s   = state_r;
        div_cnt_nxt_s = '0;
        tick_nxt_s    = 1'b0;
        case (state_r)
            ST_STOPPED: begin
                if (run_sw && !halt) begin
                    state_nxt_s = ST_RUNNING;
                end else if (step_req_s) begin
                    state_nxt_s = ST_STEP;
                    tick_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_STOPPED;
                end
            end
            ST_RUNNING: begin
                if (!run_sw) begin
                    state_nxt_s = ST_STOPPED;
                end else if (halt) begin
                    state_nxt_s = ST_HALTED;
                end else if (div_cnt_r >= div) begin
                    // >= rather than == so a lowered div fires at once instead of wrapping.
                    state_nxt_s = ST_RUNNING;
                    tick_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s   = ST_RUNNING;
                    div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
                end
            end
            ST_STEP: begin
                state_nxt_s = ST_STOPPED;
            end
            ST_HALTED: begin
                if (!run_sw) begin
                    state_nxt_s = ST_STOPPED;
                end else if (step_req_s) begin
                    state_nxt_s = ST_STEP;
                    tick_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
            default: begin
                state_nxt_s = ST_STOPPED;
            end
        endcase
    end

    // State, divider and registered outputs; phase flips on every emitted tick.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            state_r   <= ST_STOPPED;
            div_cnt_r <= '0;
            tick_r    <= 1'b0;
            phase_r   <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            div_cnt_r <= div_cnt_nxt_s;
            tick_r    <= tick_nxt_s;
            running_r <= (state_nxt_s == ST_RUNNING);
            if (tick_nxt_s) begin
                phase_r <= ~phase_r;
            end else begin
                phase_r <= phase_r;
            end
        end
    end

    assign tick    = tick_r;
    assign phase   = phase_r;
    assign running = running_r;
    assign state   = state_r;

endmodule

// File: tb/tb_clock_ctl.sv
// Self-checking bench for clock_ctl: vector table, directed corner sequences
// and randomized stimulus against a behavioural reference model.
module tb_clock_ctl;

    localparam int DIV_W = 16;
    localparam int DEB   = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             run_sw;
    logic             step_btn;
    logic             halt;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic             phase;
    logic             running;
    logic [1:0]       state;

    int n_tests = 0;
    int n_fail  = 0;

    clock_ctl #(
        .DIV_W(DIV_W),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk     (clk),
        ._reset  (reset_n),
        .run_sw  (run_sw),
        .step_btn(step_btn),
        .halt    (halt),
        .div     (div),
        .tick    (tick),
        .phase   (phase),
        .running (running),
        .state   (state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // States: 0 stopped, 1 running, 2 step, 3 halted.
    int m_state = 0;
    bit m_tick  = 1'b0;
    bit m_phase = 1'b0;
    int m_since = 0;     // evaluations in RUNNING since entry or since last tick
    bit m_s1 = 1'b0, m_s2 = 1'b0, m_deb = 1'b0, m_prev = 1'b0;
    bit m_hist[$];       // recent synchronized samples since last accepted level

    always @(posedge clk) begin : ref_model
        bit req;
        bit s2_old;
        bit flip;
        if (!reset_n) begin
            m_state = 0; m_tick = 1'b0; m_phase = 1'b0; m_since = 0;
            m_s1 = 1'b0; m_s2 = 1'b0; m_deb = 1'b0; m_prev = 1'b0;
            m_hist = {};
        end else begin
            req    = m_deb & ~m_prev;
            m_tick = 1'b0;
            case (m_state)
                0: begin
                    if (run_sw && !halt) begin m_state = 1; m_since = 0; end
                    else if (req) begin m_state = 2; m_tick = 1'b1; end
                end
                1: begin
                    if (!run_sw) m_state = 0;
                    else if (halt) m_state = 3;
                    else begin
                        m_since++;
                        if (m_since > int'(div)) begin m_tick = 1'b1; m_since = 0; end
                    end
                end
                2: m_state = 0;
                default: begin
                    if (!run_sw) m_state = 0;
                    else if (req) begin m_state = 2; m_tick = 1'b1; end
                end
            endcase
            if (m_tick) m_phase = ~m_phase;
            // A level is accepted once the last DEB synchronized samples all disagree with it.
            s2_old = m_s2;
            m_hist.push_back(s2_old);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
            flip = (m_hist.size() == DEB);
            foreach (m_hist[i]) if (m_hist[i] == m_deb) flip = 1'b0;
            m_prev = m_deb;
            if (flip) begin m_deb = s2_old; m_hist = {}; end
            m_s2 = m_s1;
            m_s1 = step_btn;
        end
    end

    // Every cycle: DUT against model, sampled on the falling edge.
    always @(negedge clk) begin
        n_tests++;
        if (tick !== m_tick || phase !== m_phase || state !== 2'(m_state) ||
            running !== (m_state == 1)) begin
            n_fail++;
            $display("FAIL model t=%0t tick/phase/state/running got %b/%b/%0d/%b expected %b/%b/%0d/%b",
                     $time, tick, phase, state, running, m_tick, m_phase, m_state, (m_state == 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; run_sw = 1'b0; halt = 1'b0; step_btn = 1'b0; div = '0;
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    typedef struct {
        logic        rst_n;
        logic        run;
        logic [15:0] dv;
        logic        e_tick;
        logic        e_phase;
        logic [1:0]  e_state;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rn, input logic [15:0] d,
                                input logic t, input logic p, input logic [1:0] s);
        vec_t v;
        v.rst_n = r; v.run = rn; v.dv = d; v.e_tick = t; v.e_phase = p; v.e_state = s;
        return v;
    endfunction

    vec_t tbl[22];
    int   tcount;
    bit   found;

    initial begin
        reset_n = 1'b0; run_sw = 1'b0; halt = 1'b0; step_btn = 1'b0; div = '0;

        // Reset, run at div=3 (ticks every 4 cycles, phase 1,0,1), stop, reset mid-run.
        tbl[0]  = mk(1'b0, 1'b0, 16'd3, 1'b0, 1'b0, 2'd0);
        tbl[1]  = mk(1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 2'd1);
        tbl[2]  = mk(1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 2'd1);
        tbl[3]  = mk(1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 2'd1);
        tbl[4]  = mk(1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 2'd1);
        tbl[5]  = mk(1'b1, 1'b1, 16'd3, 1'b1, 1'b1, 2'd1);
        tbl[6]  = mk(1'b1, 1'b1, 16'd3, 1'b0, 1'b1, 2'd1);
        tbl[7]  = mk(1'b1, 1'b1, 16'd3, 1'b0, 1'b1, 2'd1);
        tbl[8]  = mk(1'b1, 1'b1, 16'd3, 1'b0, 1'b1, 2'd1);
        tbl[9]  = mk(1'b1, 1'b1, 16'd3, 1'b1, 1'b0, 2'd1);
        tbl[10] = mk(1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 2'd1);
        tbl[11] = mk(1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 2'd1);
        tbl[12] = mk(1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 2'd1);
        tbl[13] = mk(1'b1, 1'b1, 16'd3, 1'b1, 1'b1, 2'd1);
        tbl[14] = mk(1'b1, 1'b0, 16'd3, 1'b0, 1'b1, 2'd0);
        tbl[15] = mk(1'b1, 1'b1, 16'd3, 1'b0, 1'b1, 2'd1);
        tbl[16] = mk(1'b1, 1'b1, 16'd3, 1'b0, 1'b1, 2'd1);
        tbl[17] = mk(1'b1, 1'b1, 16'd3, 1'b0, 1'b1, 2'd1);
        tbl[18] = mk(1'b0, 1'b1, 16'd3, 1'b0, 1'b0, 2'd0);
        tbl[19] = mk(1'b1, 1'b0, 16'd3, 1'b0, 1'b0, 2'd0);
        tbl[20] = mk(1'b1, 1'b0, 16'd3, 1'b0, 1'b0, 2'd0);
        tbl[21] = mk(1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 2'd1);

        for (int i = 0; i < 22; i++) begin
            reset_n = tbl[i].rst_n; run_sw = tbl[i].run; div = tbl[i].dv;
            cyc();
            chk($sformatf("vec%0d {tick,phase,running,state}", i), {tick, phase, running, state},
                {tbl[i].e_tick, tbl[i].e_phase, (tbl[i].e_state == 2'd1), tbl[i].e_state});
        end

        // Clean press: single tick exactly at cycle 3+DEB, state STEP then STOPPED.
        do_reset();
        step_btn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk($sformatf("clean_press tick c%0d", k), tick, (k == 3 + DEB));
            if (k == 3 + DEB) chk("clean_press state STEP", state, 2);
            if (k == 4 + DEB) chk("clean_press state STOPPED", state, 0);
        end
        step_btn = 1'b0;
        tcount = 0;
        for (int k = 0; k < 12; k++) begin cyc(); tcount += tick; end
        chk("release no tick", tcount, 0);

        // Bouncy press 1,0,1,0,1 then stable high: exactly one tick.
        tcount = 0;
        for (int k = 0; k < 20; k++) begin
            step_btn = (k < 5) ? ((k % 2) == 0) : 1'b1;
            cyc(); tcount += tick;
        end
        chk("bouncy press ticks", tcount, 1);
        step_btn = 1'b0;
        for (int k = 0; k < 12; k++) cyc();

        // Glitch shorter than DEB samples: no tick.
        tcount = 0;
        for (int k = 0; k < 15; k++) begin
            step_btn = (k < 3);
            cyc(); tcount += tick;
        end
        chk("3-cycle glitch ticks", tcount, 0);

        // Halt exactly when div_cnt==div: HALTED without tick, then step past halt.
        do_reset();
        div = 16'd3; run_sw = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) cyc();
        halt = 1'b1;
        cyc();
        chk("halt at terminal count state", state, 3);
        chk("halt at terminal count tick", tick, 0);
        step_btn = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc();
            if (tick) found = 1'b1;
        end
        chk("halt step tick seen", found, 1);
        chk("halt step state STEP", state, 2);
        cyc();
        chk("halt step then STOPPED", state, 0);
        chk("halt step single tick", tick, 0);
        step_btn = 1'b0; halt = 1'b0;

        // div lowered from 10 to 2 while div_cnt==7: tick next cycle, then period 3.
        do_reset();
        div = 16'd10; run_sw = 1'b1;
        cyc();
        for (int k = 0; k < 7; k++) cyc();
        div = 16'd2;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            chk($sformatf("div lowered tick c%0d", k), tick, ((k - 1) % 3) == 0);
        end

        // run_sw together with step_req in STOPPED: RUNNING, no step tick.
        do_reset();
        div = 16'd3; step_btn = 1'b1;
        for (int k = 0; k < 2 + DEB; k++) cyc();
        run_sw = 1'b1;
        cyc();
        chk("run beats step state", state, 1);
        chk("run beats step tick", tick, 0);
        cyc(); chk("run beats step later tick", tick, 0);
        run_sw = 1'b0; halt = 1'b1;
        cyc();
        chk("run off beats halt state", state, 0);
        step_btn = 1'b0; halt = 1'b0;

        // Randomized stimulus; the model checker compares every cycle.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) run_sw = ~run_sw;
            if ($urandom_range(0, 19) == 0) halt = ~halt;
            if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 99) == 0) div = DIV_W'($urandom_range(0, 6));
            reset_n = ($urandom_range(0, 499) != 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
